serial_byte_assembler: RTL and testbench

Upstream feeder for the 8-bit parallel register stage (Register8Bit1C). Collects a framed serial bit stream LSB-first into a WIDTH-bit word and optionally checks even parity. Presents the word on a valid/ready output buffer whose data bits drive that register's P inputs. Its `out_valid` qualifies the register's load.

---
 rtl/serial_byte_assembler_pkg.sv | 18 +
 rtl/serial_byte_assembler_if.sv | 24 ++
 rtl/serial_byte_assembler_shift_reg.sv | 47 ++++
 rtl/serial_byte_assembler.sv | 141 ++++++++++++++
 tb/tb_serial_byte_assembler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_byte_assembler_pkg.sv
// Shared types and defaults for the serial byte assembler.
package serial_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // XOR of all bits; 1 means the word holds an odd number of ones.
  function automatic logic even_parity(input logic [WIDTH_DEF-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_byte_assembler_if.sv
// Serial input stream plus valid/ready word output of the assembler.
interface serial_byte_assembler_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic             ovr_clr;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             parity_err;
  logic             overrun;

  modport master (
    output sin, sin_valid, frame_start, ovr_clr, out_ready,
    input  out_data, out_valid, parity_err, overrun
  );

  modport slave (
    input  sin, sin_valid, frame_start, ovr_clr, out_ready,
    output out_data, out_valid, parity_err, overrun
  );
endinterface

// File: rtl/serial_byte_assembler_shift_reg.sv
// Indexed bit-load register with clear and running parity accumulator.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o,
  output logic             par_o,
  output logic [WIDTH-1:0] word_nxt_c_o,
  output logic             par_nxt_c_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             par_q, par_d;

  // Clear takes effect first so a restart bit lands in an empty word.
  always_comb begin
    word_d = clr_i ? '0 : word_q;
    par_d  = clr_i ? 1'b0 : par_q;
    if (load_i) begin
      word_d[idx_i] = bit_i;
      par_d         = par_d ^ bit_i;
    end
  end

  // Word and parity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      par_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      par_q  <= par_d;
    end
  end

  assign word_o       = word_q;
  assign par_o        = par_q;
  assign word_nxt_c_o = word_d;
  assign par_nxt_c_o  = par_d;

endmodule

// File: rtl/serial_byte_assembler.sv
// Collects an LSB-first framed serial stream into a word with optional
// even-parity check and presents it on a one-entry valid/ready buffer.
module serial_byte_assembler
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                  Clk,
  input  logic                  reset,
  serial_byte_assembler_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             overrun_q, overrun_d;

  logic             sr_clr, sr_load, data_bit;
  logic [CNT_W-1:0] sr_idx;
  logic [WIDTH-1:0] sr_word, sr_word_nxt;
  logic             sr_par, sr_par_nxt;

  logic             complete;
  logic [WIDTH-1:0] done_word;
  logic             done_perr;

  serial_shift_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk          (Clk),
    .rst_n        (reset),
    .clr_i        (sr_clr),
    .load_i       (sr_load),
    .idx_i        (sr_idx),
    .bit_i        (bus.sin),
    .word_o       (sr_word),
    .par_o        (sr_par),
    .word_nxt_c_o (sr_word_nxt),
    .par_nxt_c_o  (sr_par_nxt)
  );

  // Frame FSM: bit placement, abort on restart, completion detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_clr    = 1'b0;
    sr_load   = 1'b0;
    sr_idx    = cnt_q;
    data_bit  = 1'b0;
    complete  = 1'b0;
    done_word = sr_word_nxt;
    done_perr = 1'b0;
    if (bus.sin_valid) begin
      if (bus.frame_start) begin
        sr_clr   = 1'b1;
        sr_load  = 1'b1;
        sr_idx   = '0;
        data_bit = 1'b1;
      end else begin
        case (state_q)
          SHIFT: begin
            sr_load  = 1'b1;
            data_bit = 1'b1;
          end
          PARITY: begin
            complete  = 1'b1;
            done_word = sr_word;
            done_perr = sr_par ^ bus.sin;
            state_d   = IDLE;
            cnt_d     = '0;
          end
          default: ;
        endcase
      end
      if (data_bit) begin
        if (sr_idx == CNT_W'(WIDTH - 1)) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d = PARITY;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end else begin
          state_d = SHIFT;
          cnt_d   = sr_idx + CNT_W'(1);
        end
      end
    end
  end

  // Output buffer, handshake and sticky overrun; a new drop beats a clear.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q & ~bus.ovr_clr;
    if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_data_d   = done_word;
        parity_err_d = done_perr;
        out_valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Bench for serial_byte_assembler (WIDTH=8, PARITY_EN=1): frame table,
// directed corner sequences, then randomized traffic against a queue model.
module tb_serial_byte_assembler;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_byte_assembler_if #(.WIDTH(8)) bus ();

  serial_byte_assembler #(
    .WIDTH     (8),
    .PARITY_EN (1),
    .CNT_W     (3)
  ) dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [8];

  // Reference model state
  logic       mq[$];
  bit         m_in_frame;
  logic [7:0] m_data;
  logic       m_valid, m_perr, m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic fs,
                     input logic rdy, input logic clr);
    bus.sin_valid   = v;
    bus.sin         = s;
    bus.frame_start = fs;
    bus.out_ready   = rdy;
    bus.ovr_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Sends 8 data bits LSB first plus a parity bit, with 0..maxgap idle cycles before each.
  task automatic send_frame(input logic [7:0] w, input logic pbit,
                            input logic rdy, input int maxgap);
    for (int i = 0; i < 9; i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap), rdy);
      if (i < 8) cyc(1'b1, w[i], (i == 0), rdy, 1'b0);
      else       cyc(1'b1, pbit, 1'b0, rdy, 1'b0);
    end
  endtask

  // Model: collect bits of the current frame in a queue; 9 bits = complete frame.
  task automatic model_step(input logic v, input logic s, input logic fs,
                            input logic rdy, input logic clr);
    bit         done;
    logic [7:0] w;
    logic       pe;
    done = 0;
    w    = '0;
    pe   = 1'b0;
    if (v) begin
      if (fs) begin
        mq.delete();
        mq.push_back(s);
        m_in_frame = 1;
      end else if (m_in_frame) begin
        mq.push_back(s);
      end
      if (m_in_frame && mq.size() == 9) begin
        for (int i = 0; i < 8; i++) w[i] = mq[i];
        for (int i = 0; i < 9; i++) pe = pe ^ mq[i];
        done = 1;
        m_in_frame = 0;
        mq.delete();
      end
    end
    m_ovr = m_ovr & ~clr;
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_perr  = pe;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic v, s, fs, rdy, clr;
    logic [7:0] part;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.sin = 0; bus.sin_valid = 0; bus.frame_start = 0;
    bus.ovr_clr = 0; bus.out_ready = 0;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[7] = '{8'h7E, 1'b0, 8'h7E, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_data",  32'(bus.out_data), 32'h00);
    chk("reset_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_perr",  32'(bus.parity_err), 32'h0);
    chk("reset_ovr",   32'(bus.overrun), 32'h0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Frame table with out_ready held high
    for (int k = 0; k < 8; k++) begin
      send_frame(vecs[k].data, vecs[k].pbit, 1'b1, 0);
      chk("tbl_valid", 32'(bus.out_valid), 32'h1);
      chk("tbl_data",  32'(bus.out_data), 32'(vecs[k].exp_data));
      chk("tbl_perr",  32'(bus.parity_err), 32'(vecs[k].exp_perr));
      idle(1, 1'b1);
      chk("tbl_fall",  32'(bus.out_valid), 32'h0);
    end

    // Overrun: second frame dropped while the first is unaccepted
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    chk("ovr_first_data", 32'(bus.out_data), 32'h3C);
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    chk("ovr_hold_data",  32'(bus.out_data), 32'h3C);
    chk("ovr_hold_valid", 32'(bus.out_valid), 32'h1);
    chk("ovr_set",        32'(bus.overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr",        32'(bus.overrun), 32'h0);
    idle(1, 1'b1);
    chk("ovr_accept",     32'(bus.out_valid), 32'h0);
    chk("ovr_keep_data",  32'(bus.out_data), 32'h3C);

    // Abort: 5 bits of a frame, then a restart carrying 0x81
    part = 8'h1F;
    for (int i = 0; i < 5; i++) cyc(1'b1, part[i], (i == 0), 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    chk("abort_data",  32'(bus.out_data), 32'h81);
    chk("abort_valid", 32'(bus.out_valid), 32'h1);
    chk("abort_perr",  32'(bus.parity_err), 32'h0);
    chk("abort_ovr",   32'(bus.overrun), 32'h0);
    idle(1, 1'b1);
    chk("abort_single", 32'(bus.out_valid), 32'h0);

    // Reset mid-frame while a word is held
    send_frame(8'h12, 1'b0, 1'b0, 0);
    chk("rst_pre_valid", 32'(bus.out_valid), 32'h1);
    part = 8'hF0;
    for (int i = 0; i < 4; i++) cyc(1'b1, part[i], (i == 0), 1'b0, 1'b0);
    bus.sin_valid = 1'b1; bus.sin = part[4]; bus.frame_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({bus.out_data, bus.out_valid, bus.parity_err, bus.overrun}), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    chk("rst_after_data", 32'(bus.out_data), 32'h55);
    chk("rst_after_perr", 32'(bus.parity_err), 32'h0);

    // Gapped bit delivery
    idle(2, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, 3);
    chk("gap_data",  32'(bus.out_data), 32'hC3);
    chk("gap_valid", 32'(bus.out_valid), 32'h1);
    chk("gap_perr",  32'(bus.parity_err), 32'h0);

    // Randomized traffic against the model
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    mq.delete();
    m_in_frame = 0; m_data = '0; m_valid = 0; m_perr = 0; m_ovr = 0;
    for (int c = 0; c < 4000; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom_range(0, 1));
      fs  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      model_step(v, s, fs, rdy, clr);
      cyc(v, s, fs, rdy, clr);
      chk("rand", 32'({bus.out_data, bus.out_valid, bus.parity_err, bus.overrun}),
          32'({m_data, m_valid, m_perr, m_ovr}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
